// File: rtl/dance_pkg.sv
// Shared types for the dance choreography controller: step word layout,
// FSM states and the signed position/delta adder.
package dance_pkg;

    localparam int CTRL_W = 5;

    typedef struct packed {
        logic [7:0]        dur;
        logic signed [3:0] dx;
        logic signed [3:0] dy;
        logic [1:0]        colour;
        logic [1:0]        sid;
    } step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    function automatic logic signed [11:0] step_sum(
        input logic [10:0]        p,
        input logic signed [3:0]  d
    );
        return $signed({1'b0, p}) + $signed({{8{d[3]}}, d});
    endfunction

endpackage

// File: rtl/choreo_ram.sv
// Step table: register file with synchronous write and registered read.
module choreo_ram
    import dance_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  step_t         wdata,
    input  logic [AW-1:0] raddr,
    output step_t         rdata
);

    step_t mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dance_choreo.sv
// Choreography controller driving sprite x0/y0/ctrl from a step table.
// Optional DANCE_BOUNCE_EN: a clamped axis reverses its delta for the step.
module dance_choreo
    import dance_pkg::*;
#(
    parameter int STEPS_W = 4,
    parameter int X_MAX   = 608,
    parameter int Y_MAX   = 448,
    parameter int X_INIT  = 304,
    parameter int Y_INIT  = 224
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic               wr_en,
    input  logic [STEPS_W-1:0] wr_addr,
    input  logic [19:0]        wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic [STEPS_W-1:0] last_step,
    input  logic               loop,
    output logic [10:0]        x0,
    output logic [10:0]        y0,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               busy,
    output logic [STEPS_W-1:0] step_idx,
    output logic               done
);

    localparam logic [STEPS_W-1:0] IDX_ONE = 1;

    state_e             state, st_d;
    logic [STEPS_W-1:0] idx_d;
    logic               done_d;
    logic [10:0]        x_q;
    logic               tick;
    logic               run_tick;
    logic [7:0]         cnt;
    logic signed [3:0]  dx_q, dy_q;
    step_t              rd_q;
    logic signed [11:0] sx, sy;
    logic [10:0]        nx, ny;

    // Read address follows the next step index so data is ready in LOAD.
    choreo_ram #(.AW(STEPS_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (step_t'(wr_data)),
        .raddr (idx_d),
        .rdata (rd_q)
    );

    assign tick     = (x_q == 11'd0) && (x == 11'd1) && (y == 11'd0);
    assign run_tick = (state == RUN) && tick && !stop && !start;
    assign busy     = (state != IDLE);

    always_comb begin
        st_d   = state;
        idx_d  = step_idx;
        done_d = 1'b0;
        if (stop) begin
            st_d = IDLE;
        end else if (start) begin
            st_d  = LOAD;
            idx_d = '0;
        end else begin
            unique case (state)
                IDLE: st_d = IDLE;
                LOAD: st_d = RUN;
                RUN: begin
                    if (tick && cnt == 8'd1) begin
                        if (step_idx != last_step) begin
                            idx_d = step_idx + IDX_ONE;
                            st_d  = LOAD;
                        end else if (loop) begin
                            idx_d = '0;
                            st_d  = LOAD;
                        end else begin
                            st_d   = IDLE;
                            done_d = 1'b1;
                        end
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    assign sx = step_sum(x0, dx_q);
    assign sy = step_sum(y0, dy_q);

    always_comb begin
        nx = sx[10:0];
        if (sx < 0) begin
            nx = '0;
        end else if (sx > $signed(12'(X_MAX))) begin
            nx = 11'(X_MAX);
        end
        ny = sy[10:0];
        if (sy < 0) begin
            ny = '0;
        end else if (sy > $signed(12'(Y_MAX))) begin
            ny = 11'(Y_MAX);
        end
    end

`ifdef DANCE_BOUNCE_EN
    logic x_hit, y_hit;
    assign x_hit = (sx < 0) || (sx > $signed(12'(X_MAX)));
    assign y_hit = (sy < 0) || (sy > $signed(12'(Y_MAX)));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step_idx <= '0;
            done     <= 1'b0;
            x_q      <= '1;
            x0       <= 11'(X_INIT);
            y0       <= 11'(Y_INIT);
            ctrl     <= '0;
            cnt      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            state    <= st_d;
            step_idx <= idx_d;
            done     <= done_d;
            x_q      <= x;
            if (state == LOAD && !stop && !start) begin
                dx_q <= rd_q.dx;
                dy_q <= rd_q.dy;
                cnt  <= (rd_q.dur == 8'd0) ? 8'd1 : rd_q.dur;
                ctrl <= {rd_q.colour, 1'b0, rd_q.sid};
            end
            if (run_tick) begin
                x0  <= nx;
                y0  <= ny;
                cnt <= cnt - 8'd1;
`ifdef DANCE_BOUNCE_EN
                if (x_hit) dx_q <= -dx_q;
                if (y_hit) dy_q <= -dy_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dance_choreo.sv
// Directed self-checking bench for dance_choreo.
module tb_dance_choreo;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic        start, stop;
    logic [3:0]  last_step;
    logic        loop;
    logic [10:0] x0, y0;
    logic [4:0]  ctrl;
    logic        busy;
    logic [3:0]  step_idx;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;

    dance_choreo dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .last_step (last_step),
        .loop      (loop),
        .x0        (x0),
        .y0        (y0),
        .ctrl      (ctrl),
        .busy      (busy),
        .step_idx  (step_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame tick: x goes 0 then 1 on line 0.
    task automatic frame();
        x = 11'd0;
        y = 11'd0;
        cyc();
        x = 11'd1;
        cyc();
        x = 11'd5;
    endtask

    task automatic wr(input logic [3:0] a, input logic [19:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        x = 11'd5; y = 11'd5;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        start = 0; stop = 0; last_step = 0; loop = 0;
        cyc();
        cyc();
        reset = 1'b0;

        repeat (3) frame();
        chk("rst_x0", x0, 304);
        chk("rst_y0", y0, 224);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", step_idx, 0);

        // single step, no loop
        wr(4'd0, {8'd3, 4'd2, 4'hF, 2'd1, 2'd2});
        go();
        chk("s1_ctrl", ctrl, 5'b01010);
        chk("s1_busy", busy, 1);
        frame();
        chk("s1_x_t1", x0, 306);
        chk("s1_y_t1", y0, 223);
        frame();
        frame();
        chk("s1_x_end", x0, 310);
        chk("s1_y_end", y0, 221);
        chk("s1_done", done, 1);
        chk("s1_busy_end", busy, 0);
        cyc();
        chk("s1_done_low", done, 0);
        chk("s1_done_cnt", done_cnt, 1);

        // looping
        loop = 1'b1;
        go();
        repeat (5) frame();
        chk("lp_x", x0, 320);
        chk("lp_y", y0, 216);
        chk("lp_idx", step_idx, 0);
        chk("lp_busy", busy, 1);
        chk("lp_done_cnt", done_cnt, 1);

        // start and stop together while running
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", busy, 0);
        frame();
        chk("ss_x", x0, 320);
        chk("ss_y", y0, 216);
        chk("ss_ctrl", ctrl, 5'b01010);
        chk("ss_done_cnt", done_cnt, 1);

        // two steps, dur 0 then dur 2
        loop = 1'b0;
        last_step = 4'd1;
        wr(4'd0, {8'd0, 4'd1, 4'd0, 2'd2, 2'd1});
        wr(4'd1, {8'd2, 4'hF, 4'd2, 2'd3, 2'd3});
        go();
        chk("ts_ctrl0", ctrl, 5'b10001);
        chk("ts_idx0", step_idx, 0);
        frame();
        chk("ts_x1", x0, 321);
        chk("ts_idx1", step_idx, 1);
        frame();
        chk("ts_ctrl1", ctrl, 5'b11011);
        chk("ts_x2", x0, 320);
        chk("ts_y2", y0, 218);
        chk("ts_busy2", busy, 1);
        frame();
        chk("ts_x3", x0, 319);
        chk("ts_y3", y0, 220);
        chk("ts_done", done, 1);
        chk("ts_busy3", busy, 0);
        cyc();
        chk("ts_done_cnt", done_cnt, 2);

        // right-edge clamp
        wr(4'd0, {8'd41, 4'd7, 4'd0, 2'd0, 2'd0});
        wr(4'd1, {8'd2, 4'd7, 4'd0, 2'd0, 2'd0});
        go();
        repeat (41) frame();
        chk("cl_x606", x0, 606);
        frame();
        chk("cl_x608", x0, 608);
        frame();
`ifdef DANCE_BOUNCE_EN
        chk("cl_bounce", x0, 601);
`else
        chk("cl_stick", x0, 608);
`endif
        chk("cl_y", y0, 220);
        chk("cl_busy", busy, 0);

        // asynchronous reset mid-step; table survives
        go();
        frame();
        chk("ar_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("ar_x0", x0, 304);
        chk("ar_y0", y0, 224);
        chk("ar_ctrl", ctrl, 0);
        chk("ar_busy", busy, 0);
        cyc();
        reset = 1'b0;
        go();
        frame();
        chk("ar_table", x0, 311);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
